// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and parameter helpers for the sequential multiplier
package mul_seq_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) ||
               (bpc == 8) || (bpc == 16) || (bpc == 32);
    endfunction

    function automatic int nstep(input int bpc);
        return DATA_W / bpc;
    endfunction

    // NSTEP == 1 still needs a 1-bit counter so the register exists
    function automatic int cnt_width(input int bpc);
        return (nstep(bpc) > 1) ? $clog2(nstep(bpc)) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - operand and result handshakes of the sequential multiplier
interface mul_seq_ctrl_if;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] product;
    logic        busy;

    modport master (
        output start_valid, in1, in2, res_ready,
        input  start_ready, res_valid, product, busy
    );

    modport slave (
        input  start_valid, in1, in2, res_ready,
        output start_ready, res_valid, product, busy
    );
endinterface

// File: rtl/mul_chunk_pp.sv
// rtl/mul_chunk_pp.sv - one cycle's slice of the partial-product array
module mul_chunk_pp
    import mul_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4,
    parameter int IDX_W          = 3
) (
    input  logic [DATA_W-1:0]         a_i,
    input  logic [BITS_PER_CYCLE-1:0] b_chunk_i,
    input  logic [IDX_W-1:0]          idx_i,
    output logic [PROD_W-1:0]         pp_o
);

    logic [PROD_W-1:0] base;

    // Rows are bit-gated copies of the chunk-aligned multiplicand; carries past bit 63 drop
    always_comb begin
        base = {{(PROD_W-DATA_W){1'b0}}, a_i} << (int'(idx_i) * BITS_PER_CYCLE);
        pp_o = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_chunk_i[j]) begin
                pp_o = pp_o + (base << j);
            end
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - multi-cycle 32x32 unsigned multiplier with valid/ready handshakes
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_seq_ctrl_if.slave bus
);

    localparam int NSTEP = nstep(BITS_PER_CYCLE);
    localparam int CNT_W = cnt_width(BITS_PER_CYCLE);

    generate
        if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
            $error("mul_seq_ctrl: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_W-1:0]         a_q;
    logic [DATA_W-1:0]         b_q;
    logic [PROD_W-1:0]         acc_q;
    logic [PROD_W-1:0]         acc_d;
    logic [PROD_W-1:0]         pp;
    logic [BITS_PER_CYCLE-1:0] b_chunk;
    logic                      start_ready_q;
    logic                      res_valid_q;
    logic                      busy_q;

    always_comb begin
        b_chunk = b_q[int'(cnt_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
        acc_d   = acc_q + pp;
    end

    mul_chunk_pp #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .IDX_W          (CNT_W)
    ) u_chunk (
        .a_i       (a_q),
        .b_chunk_i (b_chunk),
        .idx_i     (cnt_q),
        .pp_o      (pp)
    );

    // Handshake outputs are registered alongside the state so none depend on inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q           <= bus.in1;
                        b_q           <= bus.in2;
                        acc_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= RUN;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NSTEP - 1)) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_q       <= IDLE;
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    start_ready_q <= 1'b1;
                    res_valid_q   <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.busy        = busy_q;
    assign bus.product     = acc_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed bench for mul_seq_ctrl at 4, 1 and 32 bits per cycle
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 0;
    logic        sv = 1'b0;
    logic        rr = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic        m_sr, m_rv, m_busy;
    logic [63:0] m_prod;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if if4 ();
    mul_seq_ctrl_if if1 ();
    mul_seq_ctrl_if if32 ();

    assign if4.start_valid  = sv && (sel == 0);
    assign if1.start_valid  = sv && (sel == 1);
    assign if32.start_valid = sv && (sel == 2);
    assign if4.res_ready    = rr && (sel == 0);
    assign if1.res_ready    = rr && (sel == 1);
    assign if32.res_ready   = rr && (sel == 2);
    assign if4.in1  = a_in;
    assign if4.in2  = b_in;
    assign if1.in1  = a_in;
    assign if1.in2  = b_in;
    assign if32.in1 = a_in;
    assign if32.in2 = b_in;

    mul_seq_ctrl #(.BITS_PER_CYCLE(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mul_seq_ctrl #(.BITS_PER_CYCLE(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mul_seq_ctrl #(.BITS_PER_CYCLE(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    always_comb begin
        case (sel)
            1:       begin m_sr = if1.start_ready;  m_rv = if1.res_valid;  m_busy = if1.busy;  m_prod = if1.product;  end
            2:       begin m_sr = if32.start_ready; m_rv = if32.res_valid; m_busy = if32.busy; m_prod = if32.product; end
            default: begin m_sr = if4.start_ready;  m_rv = if4.res_valid;  m_busy = if4.busy;  m_prod = if4.product;  end
        endcase
    end

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sv = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        sv = 1'b0;
        vec_cnt++;
        if (m_busy !== 1'b1 || m_sr !== 1'b0) begin
            err_cnt++;
            $display("FAIL accept: busy=%b start_ready=%b required busy=1 start_ready=0", m_busy, m_sr);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (m_rv !== 1'b1 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input string name);
        int lat;
        accept(a, b);
        wait_result(lat);
        vec_cnt++;
        if (lat !== exp_lat) begin
            err_cnt++;
            $display("FAIL %s latency: got %0d edges required %0d", name, lat, exp_lat);
        end
        vec_cnt++;
        if (m_prod !== exp) begin
            err_cnt++;
            $display("FAIL %s product: got %h required %h", name, m_prod, exp);
        end
        rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr = 1'b0;
        vec_cnt++;
        if (m_sr !== 1'b1 || m_rv !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s handoff: start_ready=%b res_valid=%b required 1/0", name, m_sr, m_rv);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (m_sr !== 1'b1 || m_rv !== 1'b0 || m_busy !== 1'b0 || m_prod !== 64'd0) begin
            err_cnt++;
            $display("FAIL reset: sr=%b rv=%b busy=%b prod=%h required 1/0/0/0", m_sr, m_rv, m_busy, m_prod);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        sel = 0;
        rr = 1'b1;
        accept(32'd3, 32'd5);
        wait_result(lat);
        vec_cnt++;
        if (lat !== 8) begin
            err_cnt++;
            $display("FAIL basic latency: got %0d required 8", lat);
        end
        vec_cnt++;
        if (m_prod !== 64'd15 || m_sr !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic product: got %h sr=%b required 000000000000000f sr=0", m_prod, m_sr);
        end
        @(posedge clk);
        @(negedge clk);
        rr = 1'b0;
        vec_cnt++;
        if (m_sr !== 1'b1 || m_rv !== 1'b0 || m_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic handoff: sr=%b rv=%b busy=%b required 1/0/0", m_sr, m_rv, m_busy);
        end
    endtask

    task automatic test_corners();
        sel = 0;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8, "max");
        do_op(32'd0, 32'hDEAD_BEEF, 64'd0, 8, "zero_a");
        do_op(32'hCAFE_F00D, 32'd0, 64'd0, 8, "zero_b");
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 8, "top_bits");
    endtask

    task automatic test_hold();
        int lat;
        sel = 0;
        accept(32'h0000_1234, 32'h0000_0100);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            sv = ~sv;
            a_in = $urandom;
            b_in = $urandom;
            @(posedge clk);
            @(negedge clk);
            vec_cnt++;
            if (m_rv !== 1'b1 || m_prod !== 64'h0000_0000_0012_3400 || m_busy !== 1'b1 || m_sr !== 1'b0) begin
                err_cnt++;
                $display("FAIL hold cycle %0d: rv=%b prod=%h busy=%b sr=%b required 1/0000000000123400/1/0",
                         i, m_rv, m_prod, m_busy, m_sr);
            end
        end
        sv = 1'b0;
        rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr = 1'b0;
        vec_cnt++;
        if (m_sr !== 1'b1 || m_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold release: sr=%b busy=%b required 1/0", m_sr, m_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        sel = 0;
        accept(32'hDEAD_BEEF, 32'h1111_1111);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (m_sr !== 1'b1 || m_rv !== 1'b0 || m_busy !== 1'b0 || m_prod !== 64'd0) begin
            err_cnt++;
            $display("FAIL mid_reset: sr=%b rv=%b busy=%b prod=%h required 1/0/0/0", m_sr, m_rv, m_busy, m_prod);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 8, "after_reset");
    endtask

    task automatic test_sweep();
        logic [31:0] a, b;
        sel = 1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom;
            do_op(a, b, 64'(a) * 64'(b), 32, "bpc1");
        end
        sel = 2;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1, "bpc32_max");
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom;
            do_op(a, b, 64'(a) * 64'(b), 1, "bpc32");
        end
        sel = 0;
    endtask

    task automatic test_back_to_back();
        int lat;
        sel = 0;
        @(negedge clk);
        sv = 1'b1; a_in = 32'd7; b_in = 32'd9; rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in = 32'h0001_0000; b_in = 32'h0001_0000;
        vec_cnt++;
        if (m_sr !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b first accept: sr=%b required 0", m_sr);
        end
        wait_result(lat);
        vec_cnt++;
        if (lat !== 8 || m_prod !== 64'd63) begin
            err_cnt++;
            $display("FAIL b2b first result: lat=%0d prod=%h required 8/000000000000003f", lat, m_prod);
        end
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (m_sr !== 1'b1 || m_busy !== 1'b0 || m_rv !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b handoff: sr=%b busy=%b rv=%b required 1/0/0", m_sr, m_busy, m_rv);
        end
        @(posedge clk);
        @(negedge clk);
        sv = 1'b0;
        vec_cnt++;
        if (m_sr !== 1'b0 || m_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b second accept: sr=%b busy=%b required 0/1", m_sr, m_busy);
        end
        wait_result(lat);
        vec_cnt++;
        if (lat !== 8 || m_prod !== 64'h0000_0001_0000_0000) begin
            err_cnt++;
            $display("FAIL b2b second result: lat=%0d prod=%h required 8/0000000100000000", lat, m_prod);
        end
        @(posedge clk);
        @(negedge clk);
        rr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential controller for the 32x32 unsigned partial-product multiplier datapath.
- Accepts one operand pair through a valid/ready handshake and latches both operands.
- Each cycle, forms BITS_PER_CYCLE shifted partial products and accumulates them into a 64-bit product register.
- Presents the product through a second valid/ready handshake.
- Sits between the issuing pipeline stage and the result writeback path, replacing the single-cycle 32-row partial-product array with a fixed-latency shared resource.

## Interface
- BITS_PER_CYCLE, 4, multiplier bits (partial-product rows) consumed per RUN cycle; legal values 1, 2, 4, 8, 16, 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operand pair valid.
- start_ready  output  1  controller can accept operands.
- in1  input  32  multiplicand.
- in2  input  32  multiplier.
- res_valid  output  1  product valid.
- res_ready  input  1  consumer accepts product.
- product  output  64  unsigned in1*in2.
- busy  output  1  high in RUN or DONE.

## Operation
- NSTEP = 32/BITS_PER_CYCLE.
- States:
  - IDLE: start_ready=1.
  - RUN: cnt counts 0..NSTEP-1.
  - DONE: res_valid=1.
- IDLE→RUN when start_valid&&start_ready at the edge.
  - At that edge: a_q<=in1, b_q<=in2, acc<=0, cnt<=0.
- RUN, per edge:
  - acc <= acc + sum over j in 0..BITS_PER_CYCLE-1 of (b_q[cnt*BITS_PER_CYCLE+j] ? {32'd0,a_q} << (cnt*BITS_PER_CYCLE+j) : 0).
  - cnt <= cnt+1.
  - When cnt==NSTEP-1, the same edge moves to DONE.
- DONE→IDLE on the edge where res_valid&&res_ready.
- product is driven from acc.
  - product is stable and equal to a_q*b_q throughout DONE.
  - product is undefined-but-deterministic outside DONE; the consumer qualifies it with res_valid.
- Width rule:
  - All accumulation is 64-bit unsigned; the product never exceeds 2^64-1, so no overflow handling is required.
  - Chunk sum uses a 64-bit adder tree; carries beyond bit 63 are discarded.
- Boundaries:
  - start_valid in RUN/DONE is ignored, since start_ready=0; the operand source holds its request.
  - in1/in2 changes after acceptance have no effect.
  - res_ready asserted outside DONE has no effect.
  - No accept in the same cycle as result handoff; the next accept happens no earlier than the cycle after DONE→IDLE.
- Reset, any time including mid-RUN:
  - state=IDLE, cnt=0, acc=0, a_q=0, b_q=0.
  - Outputs after reset: start_ready=1, res_valid=0, busy=0, product=0.
  - In-flight operation is discarded.

## Timing
- Accept edge E0.
- RUN occupies the N cycles following E0, with edges E1..EN.
- res_valid rises after EN: N edges after acceptance, 8 at the default parameter.
- Result handoff edge Ek → start_ready=1 from the following cycle.
- Minimum initiation interval: NSTEP+2 cycles (accept, NSTEP RUN edges, handoff).
- start_ready, res_valid and busy decode from registered state only; there are no combinational paths from inputs to outputs.
- Critical path: one BITS_PER_CYCLE-row adder tree plus a 64-bit add.

## Structure
- Package mul_seq_pkg:
  - state enum IDLE/RUN/DONE, 2-bit encoding.
  - localparam NSTEP derivation and cnt width clog2(NSTEP), minimum 1.
  - Legal-parameter check.
- Sub-module mul_chunk_pp, combinational:
  - Inputs: a_q, b_q chunk, chunk index.
  - Output: the 64-bit sum of BITS_PER_CYCLE shifted, bit-gated rows.
  - It is the per-cycle slice of the full partial-product array.
- Top holds the FSM, counter, operand and accumulator registers.

## Test plan
- in1=3, in2=5, BITS_PER_CYCLE=4, res_ready=1 → res_valid exactly 8 edges after accept, product=64'd15, start_ready=1 two cycles after accept+8.
- in1=in2=32'hFFFFFFFF → product=64'hFFFFFFFE00000001; in1=0 or in2=0 → product=0.
- Hold res_ready=0 for 5 cycles in DONE while toggling start_valid and in1/in2 → product and res_valid stable, no new accept, busy=1.
- Assert rst_n low at RUN cycle 3 → start_ready=1, res_valid=0, busy=0, product=0 immediately. Then 32'h12345678*32'h9ABCDEF0 completes correctly = 64'h0B00EA4E242D2080.
- Parameter sweep BITS_PER_CYCLE=1/32 with 1000 random pairs → latency 32 and 1 respectively; all products match the reference model.
- Back-to-back requests with start_valid held high → second accept occurs the cycle after result handoff; both products correct.
